// File: rtl/z8_program_loader.sv
// Purpose: loads a framed, checksummed program image into z8 instruction memory and holds the core in reset until it is valid.
// Latency: the write strobe follows the edge that accepts a word's last byte by one cycle; the flags update on the CSUM edge.
// Backpressure: rx_ready is high in every state except DONE; gaps in rx_valid stall all progress with no timeout.
module z8_program_loader #(
    parameter int INSTR_WIDTH = 16,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    output logic                   rx_ready,
    input  logic                   reload,
    output logic                   imem_we,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    output logic [INSTR_WIDTH-1:0] imem_wdata,
    output logic                   core_reset,
    output logic                   load_done,
    output logic                   load_error
);

    localparam int BYTES = INSTR_WIDTH / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);
    localparam logic [7:0]     SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [7:0]             r_len;
    logic [7:0]             r_csum;
    logic [7:0]             r_word_idx;
    logic [BCW-1:0]         r_byte_cnt;
    logic [INSTR_WIDTH-1:0] r_asm;
    logic                   r_we;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [INSTR_WIDTH-1:0] r_wdata;
    logic                   r_core_reset;
    logic                   r_load_done;
    logic                   r_load_error;

    logic                   w_xfer;
    logic                   w_word_end;
    logic [7:0]             w_last_idx;
    logic                   w_last_word;
    logic [INSTR_WIDTH-1:0] w_word;

    // rx_ready depends on the state alone, so no combinational path from rx_valid exists
    assign rx_ready    = (r_state != S_DONE);
    assign w_xfer      = rx_valid && rx_ready;
    assign w_word_end  = (r_byte_cnt == LAST_BYTE);
    // LEN=0 wraps to 255 here, giving the 256-word frame for free
    assign w_last_idx  = r_len - 8'd1;
    assign w_last_word = (r_word_idx == w_last_idx);
    // MSB byte arrives first, so each new byte enters at the bottom
    assign w_word      = (r_asm << 8) | INSTR_WIDTH'(rx_data);

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign core_reset = r_core_reset;
    assign load_done  = r_load_done;
    assign load_error = r_load_error;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; reload overrides any byte arriving in the same cycle
    always_comb begin
        w_state_nxt = r_state;
        if (reload) begin
            w_state_nxt = S_IDLE;
        end else if (w_xfer) begin
            case (r_state)
                S_IDLE:  if (rx_data == SYNC_BYTE) w_state_nxt = S_LEN;
                S_LEN:   w_state_nxt = S_DATA;
                S_DATA:  if (w_word_end && w_last_word) w_state_nxt = S_CSUM;
                S_CSUM:  w_state_nxt = (rx_data == r_csum) ? S_DONE : S_IDLE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Frame datapath: counters, running XOR, word assembly, memory write port and status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len        <= '0;
            r_csum       <= '0;
            r_word_idx   <= '0;
            r_byte_cnt   <= '0;
            r_asm        <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_core_reset <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (reload) begin
                r_core_reset <= 1'b1;
                r_load_done  <= 1'b0;
                r_load_error <= 1'b0;
            end else if (w_xfer) begin
                case (r_state)
                    S_IDLE: begin
                        if (rx_data == SYNC_BYTE) r_load_error <= 1'b0;
                    end
                    S_LEN: begin
                        r_len      <= rx_data;
                        r_csum     <= rx_data;
                        r_word_idx <= '0;
                        r_byte_cnt <= '0;
                    end
                    S_DATA: begin
                        r_csum <= r_csum ^ rx_data;
                        r_asm  <= w_word;
                        if (w_word_end) begin
                            r_we       <= 1'b1;
                            r_addr     <= ADDR_WIDTH'(r_word_idx);
                            r_wdata    <= w_word;
                            r_byte_cnt <= '0;
                            r_word_idx <= r_word_idx + 8'd1;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + BCW'(1);
                        end
                    end
                    S_CSUM: begin
                        if (rx_data == r_csum) begin
                            r_load_done  <= 1'b1;
                            r_core_reset <= 1'b0;
                        end else begin
                            // partially written words stay in memory; only the flag reports the bad frame
                            r_load_error <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_z8_program_loader.sv
// Purpose: self-checking bench for z8_program_loader with a write scoreboard.
// Latency: inputs driven on the falling edge, outputs sampled on the falling edge.
// Backpressure: frames are sent back-to-back or with rx_valid low every other cycle.
module tb_z8_program_loader;

    logic        clk;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        reload;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        core_reset;
    logic        load_done;
    logic        load_error;

    int checks   = 0;
    int failures = 0;
    int nwrites  = 0;

    logic [23:0] sb[$];
    logic [15:0] wbuf[256];

    z8_program_loader #(.INSTR_WIDTH(16), .ADDR_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .load_done  (load_done),
        .load_error (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Write monitor: every strobe must match the oldest outstanding expected write
    always @(negedge clk) begin
        if (!reset && imem_we) begin
            nwrites++;
            if (sb.size() == 0) begin
                chk("unexpected_write", {imem_addr, imem_wdata}, 32'hFFFF_FFFF);
            end else begin
                logic [23:0] e;
                e = sb.pop_front();
                chk("we_addr", {24'd0, imem_addr}, {24'd0, e[23:16]});
                chk("we_data", {16'd0, imem_wdata}, {16'd0, e[15:0]});
            end
        end
    end

    task automatic idle();
        rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        if (gap != 0) idle();
    endtask

    function automatic logic [7:0] csum_of(input int n);
        logic [7:0] x;
        x = n[7:0];
        for (int i = 0; i < n; i++) x = x ^ wbuf[i][15:8] ^ wbuf[i][7:0];
        return x;
    endfunction

    // Everything after SYNC; expected writes are queued as their last byte is driven
    task automatic send_body(input int n, input logic [7:0] cs, input int gap);
        send(n[7:0], gap);
        for (int i = 0; i < n; i++) begin
            send(wbuf[i][15:8], gap);
            sb.push_back({i[7:0], wbuf[i]});
            send(wbuf[i][7:0], gap);
        end
        send(cs, gap);
    endtask

    task automatic set_nominal();
        wbuf[0] = 16'h1234;
        wbuf[1] = 16'hABCD;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd1);
        chk({tag, "_we"}, {31'd0, imem_we}, 32'd0);
        chk({tag, "_addr"}, {24'd0, imem_addr}, 32'd0);
        chk({tag, "_wdata"}, {16'd0, imem_wdata}, 32'd0);
        chk({tag, "_core_reset"}, {31'd0, core_reset}, 32'd1);
        chk({tag, "_done"}, {31'd0, load_done}, 32'd0);
        chk({tag, "_err"}, {31'd0, load_error}, 32'd0);
    endtask

    task automatic check_done(input string tag);
        chk({tag, "_done"}, {31'd0, load_done}, 32'd1);
        chk({tag, "_core_reset"}, {31'd0, core_reset}, 32'd0);
        chk({tag, "_err"}, {31'd0, load_error}, 32'd0);
        chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    initial begin
        int w0;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reload   = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b0;
        @(negedge clk);

        // Nominal load, continuous valid
        set_nominal();
        send(8'hA5, 0);
        send_body(2, 8'h42, 0);
        check_done("nom");
        idle();
        chk("nom_sb_empty", sb.size(), 0);
        // Bytes offered in DONE must not be taken
        send(8'hA5, 0);
        send(8'h01, 0);
        idle();
        chk("done_hold", {31'd0, load_done}, 32'd1);

        // Reload from DONE
        do_reload();
        chk("rl_core_reset", {31'd0, core_reset}, 32'd1);
        chk("rl_done", {31'd0, load_done}, 32'd0);
        chk("rl_rx_ready", {31'd0, rx_ready}, 32'd1);

        // Checksum failure, then a good frame
        send(8'hA5, 0);
        send_body(2, 8'h43, 0);
        chk("bad_err", {31'd0, load_error}, 32'd1);
        chk("bad_core_reset", {31'd0, core_reset}, 32'd1);
        chk("bad_done", {31'd0, load_done}, 32'd0);
        chk("bad_rx_ready", {31'd0, rx_ready}, 32'd1);
        send(8'hA5, 0);
        chk("sync_clr_err", {31'd0, load_error}, 32'd0);
        send_body(2, 8'h42, 0);
        check_done("retry");

        // Leading garbage with backpressure
        do_reload();
        send(8'h00, 1);
        send(8'hFF, 1);
        send(8'h5A, 1);
        send(8'hA5, 1);
        send_body(2, 8'h42, 1);
        check_done("gap");

        // LEN=0 -> 256 words, data = address
        do_reload();
        for (int i = 0; i < 256; i++) wbuf[i] = i[15:0];
        w0 = nwrites;
        send(8'hA5, 0);
        send_body(256, csum_of(256), 0);
        check_done("len0");
        idle();
        chk("len0_writes", nwrites - w0, 256);
        chk("len0_sb_empty", sb.size(), 0);

        // Reload coincident with a SYNC transfer: the SYNC is lost, the rest is garbage
        do_reload();
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        reload   = 1'b1;
        @(negedge clk);
        reload   = 1'b0;
        rx_valid = 1'b0;
        set_nominal();
        send(8'h02, 0);
        send(8'h12, 0);
        send(8'h34, 0);
        send(8'hAB, 0);
        send(8'hCD, 0);
        send(8'h42, 0);
        idle();
        chk("rlx_done", {31'd0, load_done}, 32'd0);
        chk("rlx_core_reset", {31'd0, core_reset}, 32'd1);

        // Reset after the second data byte
        send(8'hA5, 0);
        send(8'h02, 0);
        send(8'h12, 0);
        sb.push_back({8'h00, 16'h1234});
        send(8'h34, 0);
        idle();
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("mid_rst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send(8'hA5, 0);
        send_body(2, 8'h42, 0);
        check_done("post_rst");
        idle();
        chk("final_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
